// File: rtl/mult_pkg.sv
// Shared types and helpers for the shared signed multiplier sequencer.
package mult_pkg;

  localparam int unsigned WIDTH_DEF = 8;
  localparam int unsigned ABS_W     = 32;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  typedef logic req_id_t;

  // Caller sign-extends to ABS_W and truncates the result back.
  function automatic logic [ABS_W-1:0] abs_mag(
    input logic [ABS_W-1:0] v
  );
    return v[ABS_W-1] ? -v : v;
  endfunction

endpackage

// File: rtl/mult_shift_add_core.sv
// Unsigned shift-add multiplier, one iteration per step.
// prod is the accumulator including the pending iteration.
module mult_shift_add_core #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned PROD_W = 2 * WIDTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              step,
  input  logic [WIDTH-1:0]  a,
  input  logic [WIDTH-1:0]  b,
  output logic [PROD_W-1:0] prod,
  output logic              done
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  logic [PROD_W-1:0] mcand_q, mcand_d;
  logic [PROD_W-1:0] acc_q, acc_d;
  logic [PROD_W-1:0] addend;
  logic [WIDTH-1:0]  mplier_q, mplier_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  always_comb begin
    addend   = mplier_q[0] ? mcand_q : '0;
    prod     = acc_q + addend;
    done     = step && (cnt_q == CNT_W'(WIDTH - 1));
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    if (start) begin
      mcand_d  = PROD_W'(a);
      mplier_d = b;
      acc_d    = '0;
      cnt_d    = '0;
    end else if (step) begin
      acc_d    = prod;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/mult_rr_sequencer.sv
// Round-robin front end sharing one sign-magnitude multiplier core.
// Define MULT_EARLY_ZERO_EN to cut RUN short for zero operands.
module mult_rr_sequencer
  import mult_pkg::*;
#(
  parameter int unsigned WIDTH  = WIDTH_DEF,
  parameter int unsigned PROD_W = 2 * WIDTH
) (
  input  logic              sys_clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [WIDTH-1:0]  req0_a,
  input  logic [WIDTH-1:0]  req0_b,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [WIDTH-1:0]  req1_a,
  input  logic [WIDTH-1:0]  req1_b,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [PROD_W-1:0] rsp_mag,
  output logic              rsp_sign,
  output logic              rsp_id,
  output logic              busy
);

  state_e state_q, state_d;
  req_id_t last_q, last_d;
  req_id_t id_q, id_d;
  req_id_t rsp_id_q, rsp_id_d;
  req_id_t gnt;
  logic sign_q, sign_d;
  logic rsp_sign_q, rsp_sign_d;
  logic [PROD_W-1:0] rsp_mag_q, rsp_mag_d;
  logic any_v, accept, fin;
  logic core_step, core_done;
  logic [PROD_W-1:0] core_prod;
  logic [WIDTH-1:0] a_sel, b_sel;
  logic [WIDTH-1:0] a_mag, b_mag;
`ifdef MULT_EARLY_ZERO_EN
  logic zero_q, zero_d;
`endif

  // Prefer the requester not served last when both are valid.
  always_comb begin
    any_v = req0_valid | req1_valid;
    if (req0_valid && req1_valid) gnt = ~last_q;
    else if (req0_valid)          gnt = 1'b0;
    else                          gnt = 1'b1;
    a_sel = gnt ? req1_a : req0_a;
    b_sel = gnt ? req1_b : req0_b;
    a_mag = WIDTH'(abs_mag({{(ABS_W-WIDTH){a_sel[WIDTH-1]}}, a_sel}));
    b_mag = WIDTH'(abs_mag({{(ABS_W-WIDTH){b_sel[WIDTH-1]}}, b_sel}));
  end

  always_ff @(posedge sys_clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (any_v) state_d = RUN;
      RUN: begin
`ifdef MULT_EARLY_ZERO_EN
        if (zero_q || core_done) state_d = DONE;
`else
        if (core_done) state_d = DONE;
`endif
      end
      DONE: if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req0_ready = (state_q == IDLE) && req0_valid && !gnt;
    req1_ready = (state_q == IDLE) && req1_valid && gnt;
    accept     = req0_ready | req1_ready;
    core_step  = (state_q == RUN);
    fin        = (state_q == RUN) && (state_d == DONE);
    rsp_valid  = (state_q == DONE);
    busy       = (state_q != IDLE);
  end

  always_comb begin
    last_d     = last_q;
    id_d       = id_q;
    sign_d     = sign_q;
    rsp_mag_d  = rsp_mag_q;
    rsp_sign_d = rsp_sign_q;
    rsp_id_d   = rsp_id_q;
`ifdef MULT_EARLY_ZERO_EN
    zero_d     = zero_q;
`endif
    if (accept) begin
      id_d   = gnt;
      sign_d = a_sel[WIDTH-1] ^ b_sel[WIDTH-1];
`ifdef MULT_EARLY_ZERO_EN
      zero_d = (a_mag == '0) || (b_mag == '0);
`endif
    end
    // A zero product never reports a negative sign.
    if (fin) begin
      rsp_mag_d  = core_prod;
      rsp_sign_d = sign_q & (|core_prod);
      rsp_id_d   = id_q;
    end
    if (rsp_valid && rsp_ready) last_d = rsp_id_q;
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      last_q     <= 1'b1;
      id_q       <= 1'b0;
      sign_q     <= 1'b0;
      rsp_mag_q  <= '0;
      rsp_sign_q <= 1'b0;
      rsp_id_q   <= 1'b0;
`ifdef MULT_EARLY_ZERO_EN
      zero_q     <= 1'b0;
`endif
    end else begin
      last_q     <= last_d;
      id_q       <= id_d;
      sign_q     <= sign_d;
      rsp_mag_q  <= rsp_mag_d;
      rsp_sign_q <= rsp_sign_d;
      rsp_id_q   <= rsp_id_d;
`ifdef MULT_EARLY_ZERO_EN
      zero_q     <= zero_d;
`endif
    end
  end

  assign rsp_mag  = rsp_mag_q;
  assign rsp_sign = rsp_sign_q;
  assign rsp_id   = rsp_id_q;

  mult_shift_add_core #(
    .WIDTH  (WIDTH),
    .PROD_W (PROD_W)
  ) u_core (
    .clk   (sys_clk),
    .rst   (rst),
    .start (accept),
    .step  (core_step),
    .a     (a_mag),
    .b     (b_mag),
    .prod  (core_prod),
    .done  (core_done)
  );

endmodule

// File: tb/tb_mult_rr_sequencer.sv
// Directed bench for mult_rr_sequencer.
// Honours MULT_EARLY_ZERO_EN for zero-operand latency.
module tb_mult_rr_sequencer;

  logic        sys_clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_ready, req1_ready;
  logic [7:0]  req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic        rsp_valid, rsp_ready = 1'b0;
  logic [15:0] rsp_mag;
  logic        rsp_sign, rsp_id, busy;

  int errors = 0;
  int checks = 0;

`ifdef MULT_EARLY_ZERO_EN
  localparam int ZLAT = 2;
`else
  localparam int ZLAT = 9;
`endif

  always #5 sys_clk = ~sys_clk;

  mult_rr_sequencer dut (
    .sys_clk    (sys_clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_mag    (rsp_mag),
    .rsp_sign   (rsp_sign),
    .rsp_id     (rsp_id),
    .busy       (busy)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 0);
    chk({tag, "_rsp_mag"}, 32'(rsp_mag), 0);
    chk({tag, "_rsp_sign"}, 32'(rsp_sign), 0);
    chk({tag, "_rsp_id"}, 32'(rsp_id), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_ready0"}, 32'(req0_ready), 0);
    chk({tag, "_ready1"}, 32'(req1_ready), 0);
  endtask

  // Latency counts the accepting edge as edge 1.
  task automatic run_job(input string tag, input logic id,
                         input logic [7:0] a, input logic [7:0] b,
                         input int emag, input int esign, input int elat);
    int lat;
    @(negedge sys_clk);
    if (id) begin
      req1_valid = 1'b1; req1_a = a; req1_b = b;
    end else begin
      req0_valid = 1'b1; req0_a = a; req0_b = b;
    end
    #1;
    chk({tag, "_ready"}, 32'(id ? req1_ready : req0_ready), 1);
    @(posedge sys_clk);
    #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    req0_a = 8'hAA; req1_b = 8'h55;
    lat = 1;
    while (lat < 40) begin
      @(negedge sys_clk);
      if (rsp_valid) break;
      @(posedge sys_clk);
      lat++;
    end
    chk({tag, "_lat"}, 32'(lat), 32'(elat));
    chk({tag, "_mag"}, 32'(rsp_mag), 32'(emag));
    chk({tag, "_sign"}, 32'(rsp_sign), 32'(esign));
    chk({tag, "_id"}, 32'(rsp_id), 32'(id));
    rsp_ready = 1'b1;
    @(posedge sys_clk);
    #1;
    rsp_ready = 1'b0;
    chk({tag, "_drop"}, 32'(rsp_valid), 0);
    chk({tag, "_hold"}, 32'(rsp_mag), 32'(emag));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [15:0] mag_snap;
    repeat (2) @(posedge sys_clk);
    @(negedge sys_clk);
    chk_reset_outs("reset");
    rst = 1'b0;

    run_job("p3x5", 1'b0, 8'd3, 8'd5, 15, 0, 9);
    run_job("m7x6", 1'b1, 8'(-7), 8'd6, 42, 1, 9);
    run_job("p8x6", 1'b1, 8'd8, 8'd6, 48, 0, 9);
    run_job("p5xm3", 1'b0, 8'd5, 8'(-3), 15, 1, 9);
    run_job("z0x5", 1'b0, 8'd0, 8'd5, 0, 0, ZLAT);
    run_job("m5x0", 1'b1, 8'(-5), 8'd0, 0, 0, ZLAT);
    run_job("m128sq", 1'b0, 8'h80, 8'h80, 16384, 0, 9);
    run_job("m128x1", 1'b1, 8'h80, 8'd1, 128, 1, 9);

    // Fresh reset, then both requesters valid continuously.
    @(negedge sys_clk);
    rst = 1'b1;
    @(posedge sys_clk);
    #1;
    rst = 1'b0;
    req0_a = 8'd2; req0_b = 8'd3;
    req1_a = 8'(-4); req1_b = 8'd5;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    rsp_ready = 1'b1;
    for (int j = 0; j < 4; j++) begin
      n = 0;
      do begin
        @(negedge sys_clk);
        n++;
      end while (!rsp_valid && n < 40);
      chk("rr_seen", 32'(rsp_valid), 1);
      chk("rr_id", 32'(rsp_id), 32'(j % 2));
      chk("rr_mag", 32'(rsp_mag), (j % 2) ? 20 : 6);
      chk("rr_sign", 32'(rsp_sign), 32'(j % 2));
      if (j > 0) chk("rr_period", 32'(n), 10);
    end
    @(negedge sys_clk);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rsp_ready = 1'b0;
    repeat (12) @(negedge sys_clk);

    // Backpressure in DONE with a competing request pending.
    @(negedge sys_clk);
    req0_valid = 1'b1; req0_a = 8'd9; req0_b = 8'd9;
    @(posedge sys_clk);
    #1;
    req0_valid = 1'b0;
    req1_valid = 1'b1; req1_a = 8'd1; req1_b = 8'(-1);
    n = 0;
    do begin
      @(negedge sys_clk);
      n++;
    end while (!rsp_valid && n < 40);
    mag_snap = rsp_mag;
    chk("bp_mag", 32'(rsp_mag), 81);
    for (int k = 0; k < 5; k++) begin
      @(negedge sys_clk);
      chk("bp_valid", 32'(rsp_valid), 1);
      chk("bp_stable", 32'(rsp_mag), 32'(mag_snap));
      chk("bp_ready0", 32'(req0_ready), 0);
      chk("bp_ready1", 32'(req1_ready), 0);
    end
    rsp_ready = 1'b1;
    @(posedge sys_clk);
    #1;
    rsp_ready = 1'b0;
    chk("bp_after_valid", 32'(rsp_valid), 0);
    chk("bp_after_ready1", 32'(req1_ready), 1);
    @(posedge sys_clk);
    #1;
    req1_valid = 1'b0;
    n = 0;
    do begin
      @(negedge sys_clk);
      n++;
    end while (!rsp_valid && n < 40);
    chk("bp2_mag", 32'(rsp_mag), 1);
    chk("bp2_sign", 32'(rsp_sign), 1);
    chk("bp2_id", 32'(rsp_id), 1);
    rsp_ready = 1'b1;
    @(posedge sys_clk);
    #1;
    rsp_ready = 1'b0;

    // Reset pulse during the 4th RUN cycle aborts the job.
    @(negedge sys_clk);
    req0_valid = 1'b1; req0_a = 8'd10; req0_b = 8'd10;
    @(posedge sys_clk);
    #1;
    req0_valid = 1'b0;
    repeat (3) @(posedge sys_clk);
    #1;
    rst = 1'b1;
    @(posedge sys_clk);
    #1;
    rst = 1'b0;
    chk_reset_outs("abort");
    n = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge sys_clk);
      if (rsp_valid) n++;
    end
    chk("abort_no_rsp", 32'(n), 0);
    run_job("post_rst", 1'b1, 8'(-3), 8'(-3), 9, 0, 9);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
